mem_ctrl: RTL and testbench

//   Memory access sequencer fed by the address register's 16-bit output.

---
 rtl/mem_ctrl.sv | 124 ++++++++++++
 tb/tb_mem_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Single-access memory sequencer: accepts one read or write request from IDLE,
// runs one en/ack handshake with memory, and aborts after TIMEOUT unacknowledged cycles.
//
// state  | meaning
// IDLE   | waiting for exactly one of rd_req_i / wr_req_i
// ACCESS | mem_en_o asserted, waiting for mem_ack_i or timeout
// DONE   | one-cycle done_o pulse after an acknowledged access
// ERR    | one-cycle err_o pulse after timeout or simultaneous requests
module mem_ctrl #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 8
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          rd_req_i,
    input  logic          wr_req_i,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ack_i,
    output logic [DW-1:0] rdata_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        rdata_d     = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (rd_req_i && wr_req_i) begin
                    state_d = S_ERR;
                end else if (rd_req_i || wr_req_i) begin
                    mem_addr_d  = addr_i;
                    mem_wdata_d = wdata_i;
                    mem_we_d    = wr_req_i;
                    mem_en_d    = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Ack wins over the timeout limit when both land on the same edge.
                if (mem_ack_i) begin
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = mem_rdata_i;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = S_ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign err_o       = (state_q == S_ERR);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: reset, read, write, timeout, ack at the limit,
// illegal request, ignored requests while busy, and reset during an access.
module tb_mem_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic [15:0] addr_i, wdata_i, mem_rdata_i;
    logic        rd_req_i, wr_req_i, mem_ack_i;
    logic [15:0] mem_addr_o, mem_wdata_o, rdata_o;
    logic        mem_en_o, mem_we_o, busy_o, done_o, err_o;

    int passed = 0;
    int total  = 0;

    mem_ctrl #(.AW(16), .DW(16), .TIMEOUT(8)) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rd_req_i    (rd_req_i),
        .wr_req_i    (wr_req_i),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_en_o    (mem_en_o),
        .mem_we_o    (mem_we_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .rdata_o     (rdata_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        reset_ni = 1'b0; rd_req_i = 1'b1; wr_req_i = 1'b0;
        addr_i = 16'h5555; wdata_i = 16'h6666; mem_rdata_i = 16'h7777; mem_ack_i = 1'b1;
        step(); step();
        rd_req_i = 1'b0; mem_ack_i = 1'b0;
        total++;
        if ({mem_addr_o, mem_wdata_o, rdata_o, mem_en_o, mem_we_o, busy_o, done_o, err_o} !== '0)
            $display("FAIL reset_outputs got addr=%h wdata=%h rdata=%h en=%b we=%b busy=%b done=%b err=%b want all 0",
                     mem_addr_o, mem_wdata_o, rdata_o, mem_en_o, mem_we_o, busy_o, done_o, err_o);
        else passed++;
        reset_ni = 1'b1;
        step();
        total++;
        if ({mem_en_o, busy_o, done_o, err_o, rdata_o} !== '0)
            $display("FAIL reset_release got en=%b busy=%b done=%b err=%b rdata=%h want 0",
                     mem_en_o, busy_o, done_o, err_o, rdata_o);
        else passed++;
    endtask

    task automatic test_read();
        rd_req_i = 1'b1; addr_i = 16'h1234;
        step();
        rd_req_i = 1'b0; addr_i = 16'h0000;
        total++;
        if ({mem_en_o, mem_we_o, busy_o, done_o} !== 4'b1010 || mem_addr_o !== 16'h1234)
            $display("FAIL read_access got en=%b we=%b busy=%b done=%b addr=%h want 1 0 1 0 1234",
                     mem_en_o, mem_we_o, busy_o, done_o, mem_addr_o);
        else passed++;
        mem_ack_i = 1'b1; mem_rdata_i = 16'hBEEF;
        step();
        mem_ack_i = 1'b0; mem_rdata_i = 16'h0BAD;
        total++;
        if ({mem_en_o, done_o, err_o, busy_o} !== 4'b0101 || rdata_o !== 16'hBEEF)
            $display("FAIL read_done got en=%b done=%b err=%b busy=%b rdata=%h want 0 1 0 1 BEEF",
                     mem_en_o, done_o, err_o, busy_o, rdata_o);
        else passed++;
        step();
        total++;
        if ({done_o, busy_o} !== 2'b00 || rdata_o !== 16'hBEEF)
            $display("FAIL read_idle got done=%b busy=%b rdata=%h want 0 0 BEEF", done_o, busy_o, rdata_o);
        else passed++;
    endtask

    task automatic test_write();
        wr_req_i = 1'b1; addr_i = 16'h00FF; wdata_i = 16'hA5A5;
        step();
        wr_req_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            addr_i = 16'(i + 16'h0100); wdata_i = 16'(i);
            total++;
            if ({mem_en_o, mem_we_o} !== 2'b11 || mem_wdata_o !== 16'hA5A5 || mem_addr_o !== 16'h00FF)
                $display("FAIL write_hold[%0d] got en=%b we=%b wdata=%h addr=%h want 1 1 A5A5 00FF",
                         i, mem_en_o, mem_we_o, mem_wdata_o, mem_addr_o);
            else passed++;
            if (i == 2) begin
                mem_ack_i = 1'b1; mem_rdata_i = 16'h1111;
            end
            step();
        end
        mem_ack_i = 1'b0;
        total++;
        if ({mem_en_o, done_o, err_o} !== 3'b010 || rdata_o !== 16'hBEEF)
            $display("FAIL write_done got en=%b done=%b err=%b rdata=%h want 0 1 0 BEEF",
                     mem_en_o, done_o, err_o, rdata_o);
        else passed++;
        step();
    endtask

    task automatic test_timeout();
        int en_cycles;
        rd_req_i = 1'b1; addr_i = 16'h0042; mem_rdata_i = 16'h2222;
        step();
        rd_req_i = 1'b0;
        en_cycles = 0;
        while (mem_en_o === 1'b1 && en_cycles < 20) begin
            en_cycles++;
            step();
        end
        total++;
        if (en_cycles != 8)
            $display("FAIL timeout_en_cycles got %0d want 8", en_cycles);
        else passed++;
        total++;
        if ({err_o, done_o, busy_o} !== 3'b101 || rdata_o !== 16'hBEEF)
            $display("FAIL timeout_err got err=%b done=%b busy=%b rdata=%h want 1 0 1 BEEF",
                     err_o, done_o, busy_o, rdata_o);
        else passed++;
        step();
        total++;
        if ({err_o, busy_o} !== 2'b00)
            $display("FAIL timeout_idle got err=%b busy=%b want 0 0", err_o, busy_o);
        else passed++;

        // Ack arriving in the 8th enable cycle still completes.
        rd_req_i = 1'b1; addr_i = 16'h0043;
        step();
        rd_req_i = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) begin
                mem_ack_i = 1'b1; mem_rdata_i = 16'hCAFE;
            end
            step();
        end
        mem_ack_i = 1'b0;
        total++;
        if ({done_o, err_o, mem_en_o} !== 3'b100 || rdata_o !== 16'hCAFE)
            $display("FAIL ack_at_limit got done=%b err=%b en=%b rdata=%h want 1 0 0 CAFE",
                     done_o, err_o, mem_en_o, rdata_o);
        else passed++;
        step();
    endtask

    task automatic test_illegal();
        rd_req_i = 1'b1; wr_req_i = 1'b1; addr_i = 16'h9999;
        step();
        rd_req_i = 1'b0; wr_req_i = 1'b0;
        total++;
        if ({mem_en_o, err_o, done_o, busy_o} !== 4'b0101 || mem_addr_o !== 16'h0043)
            $display("FAIL both_req got en=%b err=%b done=%b busy=%b addr=%h want 0 1 0 1 0043",
                     mem_en_o, err_o, done_o, busy_o, mem_addr_o);
        else passed++;
        step();
        total++;
        if ({err_o, busy_o} !== 2'b00)
            $display("FAIL both_req_idle got err=%b busy=%b want 0 0", err_o, busy_o);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int accesses;
        accesses = 0;
        rd_req_i = 1'b1; addr_i = 16'h0200;
        step();
        if (mem_en_o === 1'b1) accesses++;
        step();
        mem_ack_i = 1'b1; mem_rdata_i = 16'h3333;
        step();
        rd_req_i = 1'b0; mem_ack_i = 1'b0;
        total++;
        if (done_o !== 1'b1 || rdata_o !== 16'h3333)
            $display("FAIL held_req_done got done=%b rdata=%h want 1 3333", done_o, rdata_o);
        else passed++;
        step(); step();
        if (mem_en_o === 1'b1) accesses++;
        total++;
        if (accesses != 1 || busy_o !== 1'b0)
            $display("FAIL held_req_single got accesses=%0d busy=%b want 1 0", accesses, busy_o);
        else passed++;
    endtask

    task automatic test_reset_mid();
        rd_req_i = 1'b1; addr_i = 16'h0300;
        step();
        rd_req_i = 1'b0;
        total++;
        if (mem_en_o !== 1'b1)
            $display("FAIL mid_reset_pre got en=%b want 1", mem_en_o);
        else passed++;
        reset_ni = 1'b0;
        step();
        reset_ni = 1'b1;
        total++;
        if ({mem_en_o, busy_o} !== 2'b00 || mem_addr_o !== 16'h0000 || rdata_o !== 16'h0000)
            $display("FAIL mid_reset got en=%b busy=%b addr=%h rdata=%h want 0 0 0000 0000",
                     mem_en_o, busy_o, mem_addr_o, rdata_o);
        else passed++;
        mem_ack_i = 1'b1; mem_rdata_i = 16'hDEAD;
        step();
        mem_ack_i = 1'b0;
        total++;
        if ({done_o, err_o, busy_o} !== 3'b000 || rdata_o !== 16'h0000)
            $display("FAIL late_ack got done=%b err=%b busy=%b rdata=%h want 0 0 0 0000",
                     done_o, err_o, busy_o, rdata_o);
        else passed++;
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
